decode_queue: RTL

Parametrised RV32I decode stage that sits between fetch and execute. It replaces the fixed keep/nop pipeline register with a DEPTH-entry queue of decoded instructions and valid/ready handshakes on both sides. Each accepted instruction is decoded in the same cycle (immediate, control lines, CSR flags, illegal detect) and stored. The head entry is presented to execute. Register operands are not stored; execute-side issue logic reads the regfile using the rs1/rs2 indices.

---
 rtl/decode_queue_pkg.sv | 112 +++++++++++
 rtl/decode_queue_if.sv | 21 ++
 rtl/decode_queue_inst_decoder.sv | 107 ++++++++++
 rtl/decode_queue.sv | 82 ++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode encodings and the decoded-entry layout used by the
// decode queue, its decoder and the execute stage.
package decode_queue_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRA    = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FCT3_ADD  = 3'b000;
    localparam logic [2:0] FCT3_SLL  = 3'b001;
    localparam logic [2:0] FCT3_SLT  = 3'b010;
    localparam logic [2:0] FCT3_SLTU = 3'b011;
    localparam logic [2:0] FCT3_XOR  = 3'b100;
    localparam logic [2:0] FCT3_SR   = 3'b101;
    localparam logic [2:0] FCT3_OR   = 3'b110;
    localparam logic [2:0] FCT3_AND  = 3'b111;

    localparam logic [2:0] FCT3_BEQ  = 3'b000;
    localparam logic [2:0] FCT3_BNE  = 3'b001;
    localparam logic [2:0] FCT3_BLT  = 3'b100;
    localparam logic [2:0] FCT3_BGE  = 3'b101;
    localparam logic [2:0] FCT3_BLTU = 3'b110;
    localparam logic [2:0] FCT3_BGEU = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] MB_NONE = 3'b000;
    localparam logic [2:0] MB_EQ   = 3'b001;
    localparam logic [2:0] MB_NE   = 3'b010;
    localparam logic [2:0] MB_LT   = 3'b011;
    localparam logic [2:0] MB_GE   = 3'b100;
    localparam logic [2:0] MB_LTU  = 3'b101;
    localparam logic [2:0] MB_GEU  = 3'b110;
    localparam logic [2:0] MB_JUMP = 3'b111;

    localparam logic [2:0] WB_NONE = 3'b000;
    localparam logic [2:0] WB_ALU  = 3'b100;
    localparam logic [2:0] WB_PC4  = 3'b110;
    localparam logic [2:0] WB_MEM  = 3'b101;

    localparam logic [2:0] SRC_ZERO_IMM = 3'b000;
    localparam logic [2:0] SRC_PC_IMM   = 3'b100;
    localparam logic [2:0] SRC_RS1_IMM  = 3'b010;
    localparam logic [2:0] SRC_RS1_RS2  = 3'b011;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b10;
    localparam logic [1:0] MEM_WRITE = 2'b01;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  alu_ctrl;
        logic [2:0]  alu_src;
        logic [2:0]  funct3;
        logic [1:0]  memrw;
        logic [2:0]  membranch;
        logic [2:0]  wb_ctrl;
        logic        is_csr;
        logic        is_ecall;
        logic        is_mret;
        logic [11:0] csr;
        logic        illegal;
    } entry_t;

    function automatic logic [2:0] branch_code(input logic [2:0] f3);
        case (f3)
            FCT3_BEQ:  return MB_EQ;
            FCT3_BNE:  return MB_NE;
            FCT3_BLT:  return MB_LT;
            FCT3_BGE:  return MB_GE;
            FCT3_BLTU: return MB_LTU;
            FCT3_BGEU: return MB_GEU;
            default:   return MB_NONE;
        endcase
    endfunction

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic is_reg,
                                          input logic bit30);
        case (f3)
            FCT3_ADD:  return (is_reg && bit30) ? ALU_SUB : ALU_ADD;
            FCT3_SLL:  return ALU_SLL;
            FCT3_SLT:  return ALU_SLT;
            FCT3_SLTU: return ALU_SLTU;
            FCT3_XOR:  return ALU_XOR;
            FCT3_SR:   return bit30 ? ALU_SRA : ALU_SRL;
            FCT3_OR:   return ALU_OR;
            default:   return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_queue_if.sv
// Handshake bundles on either side of the decode queue: fetch -> queue and
// queue -> execute (the execute side carries the decoded head entry).
interface decode_queue_fetch_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);
endinterface

interface decode_queue_exec_if;
    import decode_queue_pkg::*;
    logic   valid;
    logic   ready;
    entry_t entry;

    modport master (output valid, output entry, input ready);
    modport slave  (input valid, input entry, output ready);
endinterface

// File: rtl/decode_queue_inst_decoder.sv
// Combinational RV32I decoder: one instruction word and its PC in, one
// decoded queue entry out.
module inst_decoder
    import decode_queue_pkg::*;
#(
    parameter bit EN_CSR = 1'b1
) (
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output entry_t      entry_o
);
    logic [2:0]  f3;
    logic [31:0] imm_i;
    entry_t      e;

    assign f3      = inst_i[14:12];
    assign imm_i   = {{20{inst_i[31]}}, inst_i[31:20]};
    assign entry_o = e;

    always_comb begin
        e          = '0;
        e.pc       = pc_i;
        e.pcp4     = pc_i + 32'd4;
        e.rd       = inst_i[11:7];
        e.rs1      = inst_i[19:15];
        e.rs2      = inst_i[24:20];
        e.funct3   = f3;
        e.csr      = inst_i[31:20];
        e.alu_ctrl = ALU_ADD;
        case (inst_i[6:0])
            OP_LUI: begin
                e.imm     = {inst_i[31:12], 12'b0};
                e.wb_ctrl = WB_ALU;
                e.alu_src = SRC_ZERO_IMM;
            end
            OP_AUIPC: begin
                e.imm     = {inst_i[31:12], 12'b0};
                e.wb_ctrl = WB_ALU;
                e.alu_src = SRC_PC_IMM;
            end
            OP_JAL: begin
                e.imm       = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
                e.wb_ctrl   = WB_PC4;
                e.alu_src   = SRC_PC_IMM;
                e.membranch = MB_JUMP;
            end
            OP_JALR: begin
                e.imm       = imm_i;
                e.wb_ctrl   = WB_PC4;
                e.alu_src   = SRC_RS1_IMM;
                e.membranch = MB_JUMP;
            end
            OP_BRA: begin
                e.imm       = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
                e.rd        = '0;
                e.alu_src   = SRC_RS1_RS2;
                e.membranch = branch_code(f3);
                e.alu_ctrl  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                e.illegal   = (f3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                e.imm     = imm_i;
                e.wb_ctrl = WB_MEM;
                e.alu_src = SRC_RS1_IMM;
                e.memrw   = MEM_READ;
            end
            OP_STORE: begin
                e.imm     = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                e.rd      = '0;
                e.alu_src = SRC_RS1_IMM;
                e.memrw   = MEM_WRITE;
            end
            OP_ALUI: begin
                // Shift-right immediates carry the funct7 bit in imm[10]; keep only shamt.
                e.imm      = (f3 == FCT3_SR) ? {27'b0, inst_i[24:20]} : imm_i;
                e.wb_ctrl  = WB_ALU;
                e.alu_src  = SRC_RS1_IMM;
                e.alu_ctrl = alu_op(f3, 1'b0, inst_i[30]);
            end
            OP_ALU: begin
                e.wb_ctrl  = WB_ALU;
                e.alu_src  = SRC_RS1_RS2;
                e.alu_ctrl = alu_op(f3, 1'b1, inst_i[30]);
            end
            OP_SYSTEM: begin
                if (EN_CSR) begin
                    e.imm      = {27'b0, inst_i[19:15]};
                    e.wb_ctrl  = (f3 != 3'b000) ? WB_ALU : WB_NONE;
                    e.alu_src  = SRC_RS1_IMM;
                    e.is_csr   = 1'b1;
                    e.is_ecall = (f3 == 3'b000) && (inst_i[31:20] == 12'h000);
                    e.is_mret  = (f3 == 3'b000) && (inst_i[31:20] == 12'h302);
                end else begin
                    e.illegal = 1'b1;
                end
            end
            default: e.illegal = 1'b1;
        endcase
        if (e.illegal) begin
            e         = '0;
            e.pc      = pc_i;
            e.pcp4    = pc_i + 32'd4;
            e.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes each accepted fetch word and holds DEPTH decoded
// entries in a circular buffer, presenting the oldest to execute.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned  DEPTH  = 2,
    parameter bit           EN_CSR = 1'b1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    decode_queue_fetch_if.slave fetch,
    decode_queue_exec_if.master exec,
    output logic [CNT_W-1:0]    count_o
);
    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    entry_t           buf_q [DEPTH];
    entry_t           dec;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             not_full, not_empty, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    inst_decoder #(.EN_CSR(EN_CSR)) u_dec (
        .inst_i  (fetch.inst),
        .pc_i    (fetch.pc),
        .entry_o (dec)
    );

    // Acceptance depends only on occupancy, so a full queue never takes a
    // word even when the head is leaving in the same cycle.
    assign not_full    = (count_q != FULL);
    assign not_empty   = (count_q != '0);
    assign push        = fetch.valid && not_full && !flush_i;
    assign pop         = exec.ready && not_empty && !flush_i;
    assign fetch.ready = not_full;
    assign exec.valid  = not_empty;
    assign exec.entry  = not_empty ? buf_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                buf_q[wr_ptr_q] <= dec;
            end
        end
    end

endmodule
